fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the bare program counter. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned words, each tagged with its PC, are buffered in a QDEPTH-entry prefetch queue for the decode/control stage. Branch and jump redirects flush the queue and discard any in-flight response.

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one word request at a
// time to instruction memory over a req/ack handshake, and buffers returned
// words (tagged with their PC) in a small prefetch queue for decode.
//
// Ports:
//   Clk, reset          clock; synchronous active-high reset
//   redirect/_pc        taken branch/jump and its target (flushes the queue)
//   mem_req/mem_addr    registered fetch request; address stable while req=1
//   mem_ack/mem_rdata   response strobe and word, sampled only while mem_req=1
//   inst_valid/_ready   head-of-queue handshake to the consumer
//   inst_data/inst_pc   head entry (combinational from the queue)
//   fetch_pc            next address to be requested
module fetch_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned INC = 4
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int unsigned PTR_W   = $clog2(QDEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned INC_LSB = $clog2(INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << INC_LSB) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] INC_A      = ADDR_W'(INC);
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_after;

    logic              ack_live, do_push, do_pop, room;
    logic [ADDR_W-1:0] redirect_tgt, seq_pc;
    logic              req_nxt;
    logic [ADDR_W-1:0] addr_nxt, fetch_pc_nxt;

    // Redirect voids any push/pop in its cycle; the queue is cleared instead.
    assign ack_live     = mem_req & mem_ack;
    assign inst_valid   = (count != '0);
    assign do_pop       = inst_valid & inst_ready & ~redirect;
    assign do_push      = (state == S_WAIT) & ack_live & ~redirect;
    assign count_after  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign room         = (count < FULL_CNT);
    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign seq_pc       = mem_addr + INC_A;
    assign inst_data    = q_data[rd_ptr];
    assign inst_pc      = q_pc[rd_ptr];

    // State register.
    always_ff @(posedge Clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (redirect || room) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ack_live) begin
                    // Keep streaming while a slot remains for the next request.
                    if (!redirect && (count_after >= FULL_CNT)) state_nxt = S_IDLE;
                end else if (redirect) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (ack_live) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered request and fetch PC.
    always_comb begin
        req_nxt      = mem_req;
        addr_nxt     = mem_addr;
        fetch_pc_nxt = redirect ? redirect_tgt : fetch_pc;
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    req_nxt  = 1'b1;
                    addr_nxt = redirect_tgt;
                end else if (room) begin
                    req_nxt  = 1'b1;
                    addr_nxt = fetch_pc;
                end
            end
            S_WAIT: begin
                if (ack_live) begin
                    if (redirect) begin
                        req_nxt  = 1'b1;
                        addr_nxt = redirect_tgt;
                    end else begin
                        fetch_pc_nxt = seq_pc;
                        if (count_after < FULL_CNT) begin
                            req_nxt  = 1'b1;
                            addr_nxt = seq_pc;
                        end else begin
                            req_nxt = 1'b0;
                        end
                    end
                end
                // Without ack the request holds its old address, even under redirect.
            end
            S_FLUSH: begin
                if (ack_live) req_nxt = 1'b0;
            end
            default: req_nxt = 1'b0;
        endcase
    end

    // Request, fetch PC and queue bookkeeping registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= RESET_VEC;
            fetch_pc <= RESET_VEC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            mem_req  <= req_nxt;
            mem_addr <= addr_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_after;
            end
        end
    end

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            q_data[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]   <= mem_addr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned QD   = 4;
    localparam int unsigned INCR = 4;
    localparam logic [31:0] RV   = 32'h0;
    localparam logic [31:0] RV_W = 32'hFFFF_FFF8;

    logic          Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          reset, redirect, mem_ack, inst_ready;
    logic [AW-1:0] redirect_pc, mem_addr, inst_pc, fetch_pc;
    logic [DW-1:0] mem_rdata, inst_data;
    logic          mem_req, inst_valid;

    logic          reset_w, mem_req_w, mem_ack_w, inst_valid_w;
    logic [AW-1:0] mem_addr_w, inst_pc_w, fetch_pc_w;
    logic [DW-1:0] mem_rdata_w, inst_data_w;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + {a[15:0], a[31:16]};
    endfunction

    assign mem_rdata   = word_of(mem_addr);
    assign mem_ack_w   = mem_req_w;
    assign mem_rdata_w = word_of(mem_addr_w);

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_VEC(RV), .QDEPTH(QD), .INC(INCR)) dut (
        .Clk(Clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .fetch_pc(fetch_pc)
    );

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_VEC(RV_W), .QDEPTH(QD), .INC(INCR)) dut_w (
        .Clk(Clk), .reset(reset_w), .redirect(1'b0), .redirect_pc(32'h0),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w),
        .inst_valid(inst_valid_w), .inst_ready(1'b1), .inst_data(inst_data_w),
        .inst_pc(inst_pc_w), .fetch_pc(fetch_pc_w)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the prefetch queue as a list, plus the one outstanding request.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc, m_addr;
    bit          m_req, m_disc;

    function automatic logic [31:0] align(input logic [31:0] a);
        return a - (a % INCR);
    endfunction

    task automatic model_edge(input bit r, input bit rd, input logic [31:0] rpc,
                              input bit ack, input bit rdy);
        bit acc;
        int sz0;
        if (r) begin
            mq.delete();
            m_fpc = RV; m_addr = RV; m_req = 0; m_disc = 0;
            return;
        end
        acc = m_req && ack;
        sz0 = mq.size();
        if (rd) begin
            mq.delete();
            m_fpc = align(rpc);
            if (!m_req) begin
                m_req = 1; m_addr = m_fpc;
            end else if (m_disc) begin
                if (acc) begin m_req = 0; m_disc = 0; end
            end else if (acc) begin
                m_addr = m_fpc;
            end else begin
                m_disc = 1;
            end
        end else begin
            if (rdy && sz0 > 0) void'(mq.pop_front());
            if (m_req) begin
                if (acc) begin
                    if (m_disc) begin
                        m_req = 0; m_disc = 0;
                    end else begin
                        mq.push_back('{pc: m_addr, data: word_of(m_addr)});
                        m_fpc = m_addr + INCR;
                        if (mq.size() < int'(QD)) m_addr = m_fpc;
                        else m_req = 0;
                    end
                end
            end else if (sz0 < int'(QD)) begin
                m_req = 1; m_addr = m_fpc;
            end
        end
    endtask

    task automatic check_model();
        chk("req", 32'(mem_req), 32'(m_req));
        if (m_req) chk("addr", mem_addr, m_addr);
        chk("fetch_pc", fetch_pc, m_fpc);
        chk("valid", 32'(inst_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst_data", inst_data, mq[0].data);
        end
    endtask

    // Ack source: 0 = driven directly, 1 = fixed latency, 2 = random (also when idle).
    int ack_mode = 0;
    int lat      = 0;
    int wait_cnt = 0;

    task automatic set_in(input bit r, input bit rd, input logic [31:0] rp,
                          input bit a, input bit rdy);
        reset = r; redirect = rd; redirect_pc = rp; mem_ack = a; inst_ready = rdy;
    endtask

    task automatic step();
        bit r, rd, a, rdy, req_pre;
        logic [31:0] rp;
        if (ack_mode == 1)      mem_ack = mem_req && (wait_cnt >= lat);
        else if (ack_mode == 2) mem_ack = ($urandom_range(0, 2) == 0);
        r = reset; rd = redirect; rp = redirect_pc; a = mem_ack; rdy = inst_ready;
        req_pre = mem_req;
        @(posedge Clk);
        model_edge(r, rd, rp, a, rdy);
        if (r || !req_pre || a) wait_cnt = 0;
        else wait_cnt++;
        #1;
        cyc++;
        check_model();
    endtask

    typedef struct {
        bit          rst, rdr;
        logic [31:0] rpc;
        bit          ack, rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // rst rdr rpc ack rdy | req addr valid pc fpc
        tbl[0] = '{1, 0, 32'h0,  0, 1, 0, 32'h0,  0, 32'h0,  32'h0};
        tbl[1] = '{0, 0, 32'h0,  0, 1, 1, 32'h0,  0, 32'h0,  32'h0};
        tbl[2] = '{0, 0, 32'h0,  1, 1, 1, 32'h4,  1, 32'h0,  32'h4};
        tbl[3] = '{0, 0, 32'h0,  1, 1, 1, 32'h8,  1, 32'h4,  32'h8};
        tbl[4] = '{0, 0, 32'h0,  1, 1, 1, 32'hC,  1, 32'h8,  32'hC};
        tbl[5] = '{0, 1, 32'h43, 1, 1, 1, 32'h40, 0, 32'h0,  32'h40};
        tbl[6] = '{0, 0, 32'h0,  1, 1, 1, 32'h44, 1, 32'h40, 32'h44};
        tbl[7] = '{0, 0, 32'h0,  0, 0, 1, 32'h44, 1, 32'h40, 32'h44};
        tbl[8] = '{0, 0, 32'h0,  0, 1, 1, 32'h44, 0, 32'h0,  32'h44};

        set_in(1, 0, 32'h0, 0, 1);
        reset_w = 1'b1;

        // Address wrap past the top of the space on the second instance.
        step();
        chk("w_rst_fpc", fetch_pc_w, RV_W);
        chk("w_rst_req", 32'(mem_req_w), 32'd0);
        chk("w_rst_valid", 32'(inst_valid_w), 32'd0);
        reset_w = 1'b0;
        step(); chk("w_addr0", mem_addr_w, 32'hFFFF_FFF8);
        step(); chk("w_addr1", mem_addr_w, 32'hFFFF_FFFC);
                chk("w_pc0", inst_pc_w, 32'hFFFF_FFF8);
                chk("w_data0", inst_data_w, word_of(32'hFFFF_FFF8));
        step(); chk("w_addr2", mem_addr_w, 32'h0);
                chk("w_fpc2", fetch_pc_w, 32'h0);
                chk("w_pc1", inst_pc_w, 32'hFFFF_FFFC);
        step(); chk("w_addr3", mem_addr_w, 32'h4);
                chk("w_pc2", inst_pc_w, 32'h0);
        reset_w = 1'b1;

        // Vector table: zero-wait streaming, redirect with same-cycle ack.
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].rst, tbl[i].rdr, tbl[i].rpc, tbl[i].ack, tbl[i].rdy);
            step();
            chk($sformatf("t%0d_req", i), 32'(mem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("t%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("t%0d_pc", i), inst_pc, tbl[i].e_pc);
                chk($sformatf("t%0d_data", i), inst_data, word_of(tbl[i].e_pc));
            end
            chk($sformatf("t%0d_fpc", i), fetch_pc, tbl[i].e_fpc);
        end

        // Redirect while the request at 0x8 is outstanding: its data is discarded.
        set_in(1, 0, 32'h0, 0, 0); step();
        set_in(0, 0, 32'h0, 0, 0); step();
        mem_ack = 1; step();
        mem_ack = 1; step();
        chk("fl_pre_addr", mem_addr, 32'h8);
        set_in(0, 1, 32'h40, 0, 0); step();
        chk("fl_valid", 32'(inst_valid), 32'd0);
        chk("fl_hold_addr", mem_addr, 32'h8);
        chk("fl_fpc", fetch_pc, 32'h40);
        set_in(0, 0, 32'h0, 0, 0); step();
        mem_ack = 1; step();
        chk("fl_drop_req", 32'(mem_req), 32'd0);
        chk("fl_drop_valid", 32'(inst_valid), 32'd0);
        mem_ack = 0; step();
        chk("fl_new_req", 32'(mem_req), 32'd1);
        chk("fl_new_addr", mem_addr, 32'h40);
        mem_ack = 1; step();
        chk("fl_first_pc", inst_pc, 32'h40);
        chk("fl_first_data", inst_data, word_of(32'h40));

        // Reset while a request is outstanding; a stale ack must be ignored.
        mem_ack = 0; step();
        set_in(1, 0, 32'h0, 1, 0); step();
        chk("rw_req", 32'(mem_req), 32'd0);
        chk("rw_fpc", fetch_pc, RV);
        chk("rw_valid", 32'(inst_valid), 32'd0);
        set_in(0, 0, 32'h0, 1, 0); step();
        chk("rw_valid2", 32'(inst_valid), 32'd0);
        chk("rw_addr", mem_addr, RV);

        // Simultaneous pop and ack with three entries queued.
        set_in(1, 0, 32'h0, 0, 0); step();
        set_in(0, 0, 32'h0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin mem_ack = 1; step(); end
        inst_ready = 1; mem_ack = 1; step();
        chk("pp_pc", inst_pc, 32'h4);
        chk("pp_addr", mem_addr, 32'h10);
        mem_ack = 0;
        step(); chk("pp_pc1", inst_pc, 32'h8);
        step(); chk("pp_pc2", inst_pc, 32'hC);
        step(); chk("pp_empty", 32'(inst_valid), 32'd0);

        // Latency-2 memory with a stalled consumer fills the queue, then one pop resumes.
        set_in(1, 0, 32'h0, 0, 0); step();
        reset = 0; ack_mode = 1; lat = 2;
        begin
            bit done = 0;
            for (int n = 0; n < 60 && !done; n++) begin
                step();
                if (!mem_req && inst_valid) done = 1;
            end
            chk("fill_done", 32'(done), 32'd1);
        end
        chk("fill_fpc", fetch_pc, 32'h10);
        chk("fill_head", inst_pc, 32'h0);
        chk("fill_req", 32'(mem_req), 32'd0);
        inst_ready = 1; step();
        chk("fill_pop_pc", inst_pc, 32'h4);
        inst_ready = 0; step();
        chk("resume_req", 32'(mem_req), 32'd1);
        chk("resume_addr", mem_addr, 32'h10);

        // Random traffic against the model.
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom_range(0, 255));
            inst_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
